// File: rtl/mem_x_stream_reader.sv
// mem_x_stream_reader
//   Read-side engine for the 1024x24 simple dual-port sample memory. Reads a
//   programmed run of words starting at any base address, with circular wrap,
//   and emits them as a valid/ready stream. A skid FIFO of depth RD_LAT+1
//   absorbs the memory read latency. Reads are credit-limited, so the stream
//   sustains one word per cycle and survives arbitrary backpressure.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle command pulse (sampled only while idle)
//   base_addr         first read address, latched on start
//   length            number of words, 0..2^ADDR_W, latched on start
//   busy              high while a run is in progress
//   done              1-cycle pulse at the end of a run
//   mem_ceb           port-B read enable
//   mem_oce           port-B output-register enable (tied high)
//   mem_adb           port-B read address
//   mem_dout          port-B read data
//   m_valid, m_ready  stream handshake
//   m_data, m_last    stream word, final-word marker
//
// mem_ceb/mem_adb are decoded from registered state in the same cycle as the
// credit check. Registering them would add a stage to the credit loop, and the
// RD_LAT+1 entry FIFO could then no longer sustain one word per cycle.

module mem_x_stream_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_ceb,
  output logic              mem_oce,
  output logic [ADDR_W-1:0] mem_adb,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]    iss_left_q, iss_left_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;

  logic [DATA_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pop;
  logic                wr;
  logic                issue;
  logic                credit_ok;
  logic [CNT_W-1:0]    inflight;

  // Pointer advance with wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Stream side of the FIFO.
  assign m_valid = (cnt_q != '0);
  assign m_data  = fifo_q[rptr_q];
  assign m_last  = m_valid && (beats_left_q == LEN_W'(1));
  assign pop     = m_valid & m_ready;

  // A read returns into the FIFO RD_LAT edges after the memory samples it.
  assign wr = pipe_q[RD_LAT-1];

  // Reads between the memory and the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

  // The credit check counts this cycle's pop, so a full FIFO being drained
  // still allows back-to-back issues.
  assign credit_ok = (cnt_q + inflight - CNT_W'(pop)) < CNT_W'(DEPTH);

  // FSM next-state and run bookkeeping.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    iss_left_d   = iss_left_q;
    beats_left_d = beats_left_q;
    done_d       = 1'b0;
    issue        = 1'b0;

    if (pop) begin
      beats_left_d = beats_left_q - LEN_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is ignored.
        if (start && !done_q) begin
          if (length != '0) begin
            rd_addr_d    = base_addr;
            iss_left_d   = length;
            beats_left_d = length;
            state_d      = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
          iss_left_d = iss_left_q - LEN_W'(1);
          if (iss_left_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && (beats_left_q == LEN_W'(1))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Return pipeline and FIFO pointer/occupancy next-state.
  always_comb begin
    pipe_d = (pipe_q << 1) | RD_LAT'(issue);
    wptr_d = wr  ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CNT_W'(wr) - CNT_W'(pop);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      iss_left_q   <= '0;
      beats_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      iss_left_q   <= iss_left_d;
      beats_left_q <= beats_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pipe_q       <= pipe_d;
    end
  end

  // Skid FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) begin
        fifo_q[wptr_q] <= mem_dout;
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mem_ceb = issue;
  assign mem_adb = rd_addr_q;
  assign mem_oce = 1'b1;

endmodule

// File: tb/tb_mem_x_stream_reader.sv
// Testbench for mem_x_stream_reader: a table of runs plus random runs,
// checked against a queue-based reference of the expected word sequence,
// with hand-written sequences for start-while-busy, start-on-done and
// mid-run reset.

module tb_mem_x_stream_reader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned RD_LAT = 1;
  localparam int          MEM_N  = 1024;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              mem_ceb;
  logic              mem_oce;
  logic [ADDR_W-1:0] mem_adb;
  logic [DATA_W-1:0] mem_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  mem_x_stream_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .mem_ceb  (mem_ceb),
    .mem_oce  (mem_oce),
    .mem_adb  (mem_adb),
    .mem_dout (mem_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  typedef struct {
    int base;
    int len;
    int mode;     // 0 ready=1, 1 random, 2 pattern 1,0,0,1, 3 stall 20 cycles
    int poke;     // >0: extra start pulse this many cycles into the run
    int exp_lat;  // expected cycles from start cycle to first m_valid, -1 none
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mem_arr [MEM_N];

  int cyc = 0;
  int txn_c0 = 0;
  int rdy_mode = 0;

  int got_data[$];
  int got_last[$];
  int got_addr[$];
  int got_cyc[$];
  int issues, beats, done_cnt, max_out, first_vld;
  logic busy_seen;
  logic prev_stall;
  logic [DATA_W-1:0] prev_data;

  function automatic logic [DATA_W-1:0] word_of(input int a);
    logic [9:0] x;
    x = 10'(a);
    return {4'hA, x, ~x};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Port-B memory in bypass mode: data is valid after the sampling edge.
  task automatic mem_model();
    forever begin
      @(posedge clk);
      if (mem_ceb) mem_dout <= mem_arr[mem_adb];
    end
  endtask

  task automatic ready_driver();
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      k = cyc - txn_c0;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = pat[3 - (k % 4)];
        default: m_ready = (k > 20);
      endcase
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_ceb) begin
          got_addr.push_back(int'(mem_adb));
          issues++;
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (m_valid && m_ready) begin
          got_data.push_back(int'(m_data));
          got_last.push_back(int'(m_last));
          got_cyc.push_back(cyc);
          beats++;
        end
        if (issues - beats > max_out) max_out = issues - beats;
        if (prev_stall) check("hold_under_backpressure", {m_valid, m_data}, {1'b1, prev_data});
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
          done_cnt++;
          check("busy_low_with_done", busy, 0);
        end
        if (busy) busy_seen = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic watchdog();
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  endtask

  task automatic clear_monitor();
    got_data.delete();
    got_last.delete();
    got_addr.delete();
    got_cyc.delete();
    issues = 0;
    beats = 0;
    done_cnt = 0;
    max_out = 0;
    first_vld = -1;
    busy_seen = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_ceb", mem_ceb, 0);
    check("rst_mem_oce", mem_oce, 1);
    check("rst_mem_adb", mem_adb, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
  endtask

  // One run: drive start, wait for done (bounded), then compare everything
  // observed against the expected word sequence.
  task automatic run_txn(input vec_t v);
    int n;
    int c0;
    int exp_a;
    clear_monitor();
    rdy_mode = v.mode;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'(v.base);
    length = 11'(v.len);
    c0 = cyc;
    txn_c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, (v.len != 0));
    check("done_after_start", done, (v.len == 0));
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (v.poke > 0 && n == v.poke) begin
        start = 1'b1;
        base_addr = 10'd700;
        length = 11'd20;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (6) @(negedge clk);
    check("beat_count", beats, v.len);
    check("issue_count", issues, v.len);
    check("done_count", done_cnt, 1);
    check("outstanding_bound", (max_out <= RD_LAT + 1), 1);
    for (int i = 0; i < v.len && i < got_data.size(); i++) begin
      exp_a = (v.base + i) % MEM_N;
      check("beat_data", got_data[i], word_of(exp_a));
      check("beat_last", got_last[i], (i == v.len - 1));
    end
    for (int i = 0; i < v.len && i < got_addr.size(); i++) begin
      check("read_addr", got_addr[i], (v.base + i) % MEM_N);
    end
    if (v.exp_lat >= 0) check("first_valid_latency", first_vld - c0, v.exp_lat);
    if (v.mode == 0 && v.len > 0 && got_cyc.size() == v.len)
      check("no_bubbles", got_cyc[v.len-1] - got_cyc[0], v.len - 1);
    if (v.len == 0) check("busy_never_set", busy_seen, 0);
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v;
    int n;

    for (int a = 0; a < MEM_N; a++) mem_arr[a] = word_of(a);
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    m_ready = 1'b0;
    mem_dout = '0;
    clear_monitor();
    prev_stall = 1'b0;
    prev_data = '0;

    fork
      cycle_counter();
      mem_model();
      ready_driver();
      monitor();
      watchdog();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{0,    4,    0, 0, 3};
    vecs[1] = '{1022, 5,    0, 0, 3};
    vecs[2] = '{100,  16,   2, 0, 3};
    vecs[3] = '{1020, 8,    1, 0, 3};
    vecs[4] = '{7,    1,    0, 0, 3};
    vecs[5] = '{500,  0,    0, 0, -1};
    vecs[6] = '{3,    1024, 0, 0, 3};
    vecs[7] = '{900,  40,   1, 0, 3};
    vecs[8] = '{1023, 3,    3, 0, 3};
    vecs[9] = '{50,   8,    0, 3, 3};
    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      v.base = int'($urandom_range(0, MEM_N - 1));
      v.len = int'($urandom_range(1, 64));
      v.mode = 1;
      v.poke = 0;
      v.exp_lat = 3;
      run_txn(v);
    end

    // length=0 start, then a start during the resulting done cycle.
    clear_monitor();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd0;
    length = 11'd0;
    @(posedge clk);
    #1;
    base_addr = 10'd10;
    length = 11'd3;
    @(negedge clk);
    check("zero_len_done_pulse", done, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("start_on_done_ignored_beats", beats, 0);
    check("start_on_done_ignored_issues", issues, 0);
    check("start_on_done_ignored_busy", busy_seen, 0);
    check("start_on_done_done_count", done_cnt, 1);

    // Mid-run reset after three beats of a ten-word run.
    clear_monitor();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd0;
    length = 11'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (beats < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (beats < 3) check("reset_seq_timeout", beats, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    check("reset_no_done", done_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v = '{5, 2, 0, 0, 3};
    run_txn(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
